// File: rtl/imm_extend_stage.sv
// Immediate extension stage: widens a raw immediate by mode behind a 2-entry skid buffer.
// Optional macro IMM_EXTEND_STATS_EN adds o_xfer_count (output transfer counter).
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_flush                 drops both held entries
//   i_valid/o_ready         upstream handshake (o_ready = skid empty)
//   i_mode                  00 zero, 01 sign, 10 upper, 11 branch
//   i_immediate_value       raw immediate
//   o_valid/i_ready/o_data  downstream handshake and extended result
//   o_xfer_count            output transfers (IMM_EXTEND_STATS_EN only)
module imm_extend_stage #(
    parameter int NB_IMM  = 16,
    parameter int NB_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [1:0]         i_mode,
    input  logic [NB_IMM-1:0]  i_immediate_value,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_data
`ifdef IMM_EXTEND_STATS_EN
    ,
    output logic [31:0]        o_xfer_count
`endif
);

    localparam int NB_PAD = NB_DATA - NB_IMM;

    logic               out_valid_q, out_valid_d;
    logic               skid_valid_q, skid_valid_d;
    logic [NB_DATA-1:0] out_data_q, out_data_d;
    logic [NB_DATA-1:0] skid_data_q, skid_data_d;
    logic [NB_DATA-1:0] sext_data;
    logic [NB_DATA-1:0] ext_data;
    logic               in_xfer;
    logic               out_xfer;

    assign o_ready  = ~skid_valid_q;
    assign o_valid  = out_valid_q;
    assign o_data   = out_valid_q ? out_data_q : '0;
    assign in_xfer  = i_valid & ~skid_valid_q;
    assign out_xfer = out_valid_q & i_ready;

    always_comb begin
        ext_data  = '0;
        sext_data = {{NB_PAD{i_immediate_value[NB_IMM-1]}}, i_immediate_value};
        unique case (i_mode)
            2'b00: ext_data = {{NB_PAD{1'b0}}, i_immediate_value};
            2'b01: ext_data = sext_data;
            2'b10: ext_data = {i_immediate_value, {NB_PAD{1'b0}}};
            2'b11: ext_data = {sext_data[NB_DATA-3:0], 2'b00};
        endcase
    end

    // Skid can only fill while the output register is stalled, so an
    // input never arrives together with a skid->output move.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (i_flush) begin
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
        end else if (!out_valid_q || out_xfer) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
                skid_data_d  = '0;
            end else if (in_xfer) begin
                out_valid_d = 1'b1;
                out_data_d  = ext_data;
            end else begin
                out_valid_d = 1'b0;
                out_data_d  = '0;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_data_d  = ext_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

`ifdef IMM_EXTEND_STATS_EN
    logic [31:0] xfer_count_q, xfer_count_d;

    // Flush does not cancel a transfer completing in the same cycle.
    always_comb begin
        xfer_count_d = xfer_count_q;
        if (out_xfer) begin
            xfer_count_d = xfer_count_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            xfer_count_q <= '0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign o_xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage against a 2-deep FIFO model.
// Covers reset, directed modes, backpressure, flush, mid-run reset, streaming, random.
module tb_imm_extend_stage;

    localparam int NB_IMM  = 16;
    localparam int NB_DATA = 32;

    logic               clk = 1'b0;
    logic               i_reset = 1'b0;
    logic               i_flush = 1'b0;
    logic               i_valid = 1'b0;
    logic               o_ready;
    logic [1:0]         i_mode = 2'b00;
    logic [NB_IMM-1:0]  i_immediate_value = '0;
    logic               o_valid;
    logic               i_ready = 1'b0;
    logic [NB_DATA-1:0] o_data;
`ifdef IMM_EXTEND_STATS_EN
    logic [31:0]        o_xfer_count;
`endif

    int checks = 0;
    int failures = 0;
    int nout = 0;
    logic [NB_DATA-1:0] exp_q[$];

    imm_extend_stage #(
        .NB_IMM (NB_IMM),
        .NB_DATA(NB_DATA)
    ) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_flush          (i_flush),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_mode           (i_mode),
        .i_immediate_value(i_immediate_value),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_data           (o_data)
`ifdef IMM_EXTEND_STATS_EN
        ,
        .o_xfer_count     (o_xfer_count)
`endif
    );

    always #5 clk = ~clk;

    // Arithmetic reference: value of the immediate under each mode, mod 2^NB_DATA.
    function automatic logic [NB_DATA-1:0] ref_ext(input logic [1:0] m,
                                                   input logic [NB_IMM-1:0] imm);
        longint u;
        longint s;
        longint r;
        u = longint'(imm);
        s = (u >= (longint'(1) << (NB_IMM - 1))) ? u - (longint'(1) << NB_IMM) : u;
        case (m)
            2'd0:    r = u;
            2'd1:    r = s;
            2'd2:    r = u * (longint'(1) << (NB_DATA - NB_IMM));
            default: r = s * 4;
        endcase
        return r[NB_DATA-1:0];
    endfunction

    // Applies current inputs across one rising edge and updates the FIFO model.
    task automatic advance();
        int sz;
        bit in_x;
        bit out_x;
        logic [NB_DATA-1:0] r;
        sz = exp_q.size();
        in_x = i_valid && (sz < 2);
        out_x = (sz > 0) && i_ready;
        r = ref_ext(i_mode, i_immediate_value);
        @(posedge clk);
        if (i_reset || i_flush) begin
            exp_q.delete();
        end else begin
            if (out_x) begin
                void'(exp_q.pop_front());
                nout++;
            end
            if (in_x) exp_q.push_back(r);
        end
        @(negedge clk);
    endtask

    task automatic set_in(input bit v, input logic [1:0] m, input logic [NB_IMM-1:0] imm);
        i_valid = v;
        i_mode = m;
        i_immediate_value = imm;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_flush = 1'b0;
        set_in(1'b0, 2'b00, '0);
        i_ready = 1'b0;
        advance();
        advance();
        i_reset = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", o_valid);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", o_ready);
        end
        checks++;
        if (o_data !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", o_data);
        end
`ifdef IMM_EXTEND_STATS_EN
        checks++;
        if (o_xfer_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", o_xfer_count);
        end
`endif
    endtask

    task automatic test_modes();
        logic [1:0]         m[4];
        logic [NB_IMM-1:0]  v[4];
        logic [NB_DATA-1:0] e[4];
        m = '{2'b01, 2'b00, 2'b10, 2'b11};
        v = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF};
        e = '{32'hFFFF8000, 32'h00008000, 32'h12340000, 32'hFFFFFFFC};
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, m[k], v[k]);
            advance();
            checks++;
            if (o_valid !== 1'b1 || o_data !== e[k]) begin
                failures++;
                $display("FAIL mode_%0d got=%b/%h exp=1/%h", k, o_valid, o_data, e[k]);
            end
            checks++;
            if (o_ready !== 1'b1) begin
                failures++;
                $display("FAIL mode_ready_%0d got=%b exp=1", k, o_ready);
            end
        end
        set_in(1'b0, 2'b00, '0);
        advance();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL mode_drain got=%b exp=0", o_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [NB_DATA-1:0] a;
        logic [NB_DATA-1:0] b;
        logic [NB_DATA-1:0] c;
        a = ref_ext(2'b01, 16'hF00D);
        b = ref_ext(2'b11, 16'h0123);
        c = ref_ext(2'b10, 16'hBEEF);
        i_ready = 1'b0;
        set_in(1'b1, 2'b01, 16'hF00D);
        advance();
        set_in(1'b1, 2'b11, 16'h0123);
        advance();
        set_in(1'b1, 2'b10, 16'hBEEF);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== a) begin
                failures++;
                $display("FAIL bp_hold_%0d got=%b/%b/%h exp=0/1/%h",
                         k, o_ready, o_valid, o_data, a);
            end
            advance();
        end
        i_ready = 1'b1;
        advance();
        checks++;
        if (o_data !== b || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_second got=%h/%b exp=%h/1", o_data, o_ready, b);
        end
        advance();
        set_in(1'b0, 2'b00, '0);
        checks++;
        if (o_valid !== 1'b1 || o_data !== c) begin
            failures++;
            $display("FAIL bp_third got=%b/%h exp=1/%h", o_valid, o_data, c);
        end
        advance();
        checks++;
        if (o_valid !== 1'b0 || o_data !== '0) begin
            failures++;
            $display("FAIL bp_empty got=%b/%h exp=0/0", o_valid, o_data);
        end
    endtask

    task automatic test_flush();
        i_ready = 1'b0;
        set_in(1'b1, 2'b00, 16'h1111);
        advance();
        set_in(1'b1, 2'b01, 16'h2222);
        advance();
        i_flush = 1'b1;
        set_in(1'b1, 2'b10, 16'h3333);
        advance();
        i_flush = 1'b0;
        set_in(1'b0, 2'b00, '0);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== '0) begin
            failures++;
            $display("FAIL flush got=%b/%b/%h exp=0/1/0", o_valid, o_ready, o_data);
        end
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            advance();
            checks++;
            if (o_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_leak_%0d got=%b/%h exp=0", k, o_valid, o_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        set_in(1'b1, 2'b01, 16'hABCD);
        advance();
        set_in(1'b1, 2'b11, 16'h8001);
        advance();
        set_in(1'b0, 2'b00, '0);
        checks++;
        if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_full got=%b/%b exp=0/1", o_ready, o_valid);
        end
        i_reset = 1'b1;
        i_ready = 1'b1;
        advance();
        i_reset = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_data !== '0 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid got=%b/%h/%b exp=0/0/1", o_valid, o_data, o_ready);
        end
        advance();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_leak got=%b exp=0", o_valid);
        end
    endtask

    task automatic test_stream();
        int start;
        int ready_drops;
        int data_errs;
        start = nout;
        ready_drops = 0;
        data_errs = 0;
        i_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            set_in(1'b1, 2'($urandom_range(0, 3)), 16'($urandom));
            advance();
            if (o_ready !== 1'b1) ready_drops++;
            if (o_valid !== 1'b1 || o_data !== exp_q[0]) data_errs++;
        end
        set_in(1'b0, 2'b00, '0);
        advance();
        checks++;
        if (ready_drops != 0) begin
            failures++;
            $display("FAIL stream_ready got=%0d drops exp=0", ready_drops);
        end
        checks++;
        if (data_errs != 0) begin
            failures++;
            $display("FAIL stream_data got=%0d errors exp=0", data_errs);
        end
        checks++;
        if (nout - start != 100 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_count got=%0d/%b exp=100/0", nout - start, o_valid);
        end
`ifdef IMM_EXTEND_STATS_EN
        checks++;
        if (o_xfer_count !== 32'd100) begin
            failures++;
            $display("FAIL stats_count got=%0d exp=100", o_xfer_count);
        end
`endif
    endtask

    task automatic test_random();
        int errs;
        int sz;
        logic [NB_DATA-1:0] ed;
        errs = 0;
        for (int k = 0; k < 400; k++) begin
            sz = exp_q.size();
            ed = (sz > 0) ? exp_q[0] : '0;
            if (o_valid !== (sz > 0) || o_data !== ed || o_ready !== (sz < 2)) begin
                errs++;
                if (errs <= 5) begin
                    $display("FAIL rand_cyc_%0d got=%b/%h/%b exp=%b/%h/%b",
                             k, o_valid, o_data, o_ready, sz > 0, ed, sz < 2);
                end
            end
            set_in(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
            i_ready = 1'($urandom_range(0, 2) != 0);
            i_flush = ($urandom_range(0, 19) == 0);
            advance();
        end
        i_flush = 1'b0;
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL rand_total got=%0d errors exp=0", errs);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_modes();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_reset();
        test_stream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
